// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying words out of the FIFO stream reader.
// The master drives valid/data and the slave drives ready.
interface fifo_stream_reader_if #(
    parameter int DWIDTH = 16
);
    logic              m_valid;
    logic [DWIDTH-1:0] m_data;
    logic              m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a BRAM-backed FIFO with a 1-cycle registered read port.
// It buffers returned words in a 2-entry skid buffer and streams them out as valid/ready.
module fifo_stream_reader #(
    parameter int DWIDTH = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fifo_empty,
    output logic                fifo_rd_ea,
    input  logic [DWIDTH-1:0]   fifo_dout,
    input  logic                flush,
    fifo_stream_reader_if.master m,
    output logic [1:0]          buf_level
);

    logic [DWIDTH-1:0] buf_q [2];
    logic [DWIDTH-1:0] buf_d [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              rd_pending_q, rd_pending_d;
    logic [1:0]        count_q, count_d;
    logic              pop;
    logic [2:0]        occupancy;

    // Words already held plus the one in flight, after this cycle's pop, must leave a free slot.
    always_comb begin
        pop        = (count_q != 2'd0) && m.m_ready;
        occupancy  = {1'b0, count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
        fifo_rd_ea = rstn && !flush && !fifo_empty && (occupancy < 3'd2);
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rd_pending_d = fifo_rd_ea;
        buf_d        = buf_q;
        if (flush) begin
            head_d       = 1'b0;
            tail_d       = 1'b0;
            count_d      = 2'd0;
            rd_pending_d = 1'b0;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            if (rd_pending_q) begin
                buf_d[tail_q] = fifo_dout;
                tail_d        = ~tail_q;
            end
            count_d = count_q + {1'b0, rd_pending_q} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= 2'd0;
            rd_pending_q <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rd_pending_q <= rd_pending_d;
            buf_q        <= buf_d;
        end
    end

    assign m.m_valid = (count_q != 2'd0);
    assign m.m_data  = buf_q[head_q];
    assign buf_level = count_q;

    // The issue rule keeps buffered plus in-flight words within the two slots.
    buffer_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        ({1'b0, count_q} + {2'b00, rd_pending_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random bench for fifo_stream_reader, with a behavioural model
// of the upstream BRAM FIFO (combinational empty flag, registered read data).
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_rd_ea;
    logic [15:0] fifo_dout = 16'h0000;
    logic [1:0]  buf_level;
    logic        force_nonempty;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int rd_pulses = 0;
    bit mon_en = 1'b0;

    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [15:0] got [$];
    int          got_cyc [$];
    logic [15:0] exp_q [$];

    fifo_stream_reader_if #(.DWIDTH(16)) m_if ();

    fifo_stream_reader #(.DWIDTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_rd_ea (fifo_rd_ea),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m          (m_if),
        .buf_level  (buf_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    assign fifo_empty = force_nonempty ? 1'b0 : (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_ea && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Per-cycle protocol checks plus a log of every accepted word, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks = checks + 1;
            assert (!(fifo_rd_ea && fifo_empty)) else begin
                errors = errors + 1;
                $error("[TB] FAIL rd_while_empty: observed rd_ea=%0b empty=%0b expected no read", fifo_rd_ea, fifo_empty);
            end
            checks = checks + 1;
            assert (buf_level <= 2'd2) else begin
                errors = errors + 1;
                $error("[TB] FAIL buf_level_range: observed %0d expected <= 2", buf_level);
            end
            if (fifo_rd_ea) rd_pulses = rd_pulses + 1;
            if (rstn && !flush && m_if.m_valid && m_if.m_ready) begin
                got.push_back(m_if.m_data);
                got_cyc.push_back(cycle);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic fl);
        @(posedge clk);
        #1;
        m_if.m_ready = ready;
        flush        = fl;
        #1;
    endtask

    task automatic pushWord(input logic [15:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    initial begin
        int base;
        int base_rd;
        int n;
        logic [15:0] v;

        rstn           = 1'b0;
        flush          = 1'b0;
        m_if.m_ready   = 1'b0;
        force_nonempty = 1'b1;
        #1;
        checkOutput("reset_rd_ea_t0", {31'd0, fifo_rd_ea}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("reset_rd_ea", {31'd0, fifo_rd_ea}, 32'd0);
            checkOutput("reset_m_valid", {31'd0, m_if.m_valid}, 32'd0);
            checkOutput("reset_buf_level", {30'd0, buf_level}, 32'd0);
        end
        checkOutput("reset_m_data", {16'd0, m_if.m_data}, 32'd0);
        rstn           = 1'b1;
        force_nonempty = 1'b0;
        #1;
        checkOutput("idle_rd_ea", {31'd0, fifo_rd_ea}, 32'd0);
        mon_en = 1'b1;

        // Single word: read at t, data at t+1, visible at t+2.
        pushWord(16'hA001);
        #1;
        checkOutput("lat_rd_ea_t", {31'd0, fifo_rd_ea}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("lat_rd_ea_t1", {31'd0, fifo_rd_ea}, 32'd0);
        checkOutput("lat_m_valid_t1", {31'd0, m_if.m_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("lat_m_valid_t2", {31'd0, m_if.m_valid}, 32'd1);
        checkOutput("lat_m_data_t2", {16'd0, m_if.m_data}, 32'h0000A001);
        checkOutput("lat_buf_level_t2", {30'd0, buf_level}, 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("lat_m_data_hold", {16'd0, m_if.m_data}, 32'h0000A001);
        applyStimulus(1'b0, 1'b0);
        checkOutput("lat_drained_valid", {31'd0, m_if.m_valid}, 32'd0);
        checkOutput("lat_drained_level", {30'd0, buf_level}, 32'd0);
        checkOutput("lat_got_count", got.size(), 32'd1);
        if (got.size() > 0) checkOutput("lat_got_word", {16'd0, got[0]}, 32'h0000A001);

        // Preloaded streaming: one word per cycle after the first.
        base = got.size();
        for (int i = 1; i <= 8; i++) pushWord(16'(i));
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 30 && (got.size() - base) < 8; k++) applyStimulus(1'b1, 1'b0);
        m_if.m_ready = 1'b0;
        checkOutput("stream_count", got.size() - base, 32'd8);
        n = got.size() - base;
        for (int i = 0; i < 8 && i < n; i++) begin
            checkOutput($sformatf("stream_word%0d", i), {16'd0, got[base + i]}, 32'(i + 1));
            checkOutput($sformatf("stream_gap%0d", i), got_cyc[base + i] - got_cyc[base], 32'(i));
        end

        // Backpressure: only two words drawn, head word held stable.
        base_rd = rd_pulses;
        base    = got.size();
        for (int i = 0; i < 5; i++) pushWord(16'hB000 + 16'(i));
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0);
            if (k >= 2) begin
                checkOutput($sformatf("bp_m_valid_c%0d", k), {31'd0, m_if.m_valid}, 32'd1);
                checkOutput($sformatf("bp_m_data_c%0d", k), {16'd0, m_if.m_data}, 32'h0000B000);
            end
        end
        checkOutput("bp_rd_pulses", rd_pulses - base_rd, 32'd2);
        checkOutput("bp_buf_level", {30'd0, buf_level}, 32'd2);
        checkOutput("bp_rd_ea_idle", {31'd0, fifo_rd_ea}, 32'd0);
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 30 && (got.size() - base) < 5; k++) applyStimulus(1'b1, 1'b0);
        m_if.m_ready = 1'b0;
        checkOutput("bp_count", got.size() - base, 32'd5);
        n = got.size() - base;
        for (int i = 0; i < 5 && i < n; i++)
            checkOutput($sformatf("bp_word%0d", i), {16'd0, got[base + i]}, 32'h0000B000 + 32'(i));

        // Flush with one word buffered (C001) and one in flight (C002): both are lost.
        base = got.size();
        for (int i = 1; i <= 4; i++) pushWord(16'hC000 + 16'(i));
        #1;
        checkOutput("fl_rd_ea_start", {31'd0, fifo_rd_ea}, 32'd1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fl_pre_level", {30'd0, buf_level}, 32'd1);
        checkOutput("fl_pre_m_data", {16'd0, m_if.m_data}, 32'h0000C001);
        flush = 1'b1;
        #1;
        checkOutput("fl_rd_ea_gated", {31'd0, fifo_rd_ea}, 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("fl_m_valid", {31'd0, m_if.m_valid}, 32'd0);
        checkOutput("fl_buf_level", {30'd0, buf_level}, 32'd0);
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 30 && (got.size() - base) < 2; k++) applyStimulus(1'b1, 1'b0);
        m_if.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("fl_count", got.size() - base, 32'd2);
        n = got.size() - base;
        if (n > 0) checkOutput("fl_word0", {16'd0, got[base]}, 32'h0000C003);
        if (n > 1) checkOutput("fl_word1", {16'd0, got[base + 1]}, 32'h0000C004);

        // Random traffic against the push order.
        base = got.size();
        for (int k = 0; k < 2000; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1 && (wr_ptr - rd_ptr) < 200) begin
                v = 16'($urandom);
                pushWord(v);
                exp_q.push_back(v);
            end
        end
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 400 && (got.size() - base) < exp_q.size(); k++) applyStimulus(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        checkOutput("rand_count", got.size() - base, exp_q.size());
        n = got.size() - base;
        for (int i = 0; i < exp_q.size() && i < n; i++)
            checkOutput($sformatf("rand_word%0d", i), {16'd0, got[base + i]}, {16'd0, exp_q[i]});

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
